cmd_timing_sequencer: RTL and testbench

CMD_TIMING_SEQUENCER -- requirements
Module: cmd_timing_sequencer

---
 rtl/cmd_timing_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cmd_timing_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_timing_sequencer.sv
// Single-bank DRAM command sequencer: ACT -> RD/WR -> data burst -> PRE.
// Inter-command spacing is measured by an external countdown timer that this
// block loads through TimerRst/TimerLoad and observes through HitZero.
module cmd_timing_sequencer #(
  parameter int T_RCD = 16,
  parameter int T_RP  = 16,
  parameter int T_CL  = 16,
  parameter int T_CWL = 12,
  parameter int T_WR  = 18,
  parameter int T_RTP = 9,
  parameter int BL    = 8
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [3:0]  ReqBank,
  input  logic [16:0] ReqRow,
  input  logic [9:0]  ReqCol,
  output logic [2:0]  Cmd,
  output logic [3:0]  CmdBank,
  output logic [16:0] CmdAddr,
  output logic        RdDataEn,
  output logic        WrDataEn,
  output logic        Busy,
  output logic        Done,
  output logic        TimerRst,
  output logic [31:0] TimerLoad,
  input  logic        HitZero
);

  typedef enum logic [3:0] {
    IDLE,
    ACT,
    WAIT_RCD,
    CAS,
    WAIT_LAT,
    BURST,
    RECOVER,
    PRE,
    WAIT_RP
  } state_t;

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_ACT = 3'b001;
  localparam logic [2:0] CMD_RD  = 3'b010;
  localparam logic [2:0] CMD_WR  = 3'b011;
  localparam logic [2:0] CMD_PRE = 3'b100;

  // Timer reloads are biased so the wait state sees HitZero one clock before
  // the following command is due (load at edge, count down, exit on zero).
  localparam logic [31:0] LOAD_RCD = 32'(T_RCD - 2);
  localparam logic [31:0] LOAD_RP  = 32'(T_RP - 2);
  localparam logic [31:0] LOAD_CL  = 32'(T_CL - 2);
  localparam logic [31:0] LOAD_CWL = 32'(T_CWL - 2);
  localparam logic [31:0] LOAD_WR  = 32'(T_WR - 1);
  localparam logic [31:0] LOAD_RTP = 32'(T_RTP - 1);
  localparam logic [1:0]  LAST_BEAT = 2'(BL / 2 - 1);

  state_t      state;
  logic        lat_write;
  logic [3:0]  lat_bank;
  logic [16:0] lat_row;
  logic [9:0]  lat_col;
  logic [1:0]  beat;
  logic        last_beat;

  assign last_beat = (beat == LAST_BEAT);

  // State register, request latch and burst beat counter.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state     <= IDLE;
      lat_write <= 1'b0;
      lat_bank  <= '0;
      lat_row   <= '0;
      lat_col   <= '0;
      beat      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            lat_write <= ReqWrite;
            lat_bank  <= ReqBank;
            lat_row   <= ReqRow;
            lat_col   <= ReqCol;
            state     <= ACT;
          end
        end
        ACT:      state <= WAIT_RCD;
        WAIT_RCD: if (HitZero) state <= CAS;
        CAS:      state <= WAIT_LAT;
        WAIT_LAT: begin
          if (HitZero) begin
            beat  <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (last_beat) state <= RECOVER;
          else           beat  <= beat + 2'd1;
        end
        RECOVER:  if (HitZero) state <= PRE;
        PRE:      state <= WAIT_RP;
        WAIT_RP:  if (HitZero) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Output decode from state, latched request, beat counter and HitZero.
  always_comb begin
    ReqReady  = 1'b0;
    Cmd       = CMD_NOP;
    CmdBank   = '0;
    CmdAddr   = '0;
    RdDataEn  = 1'b0;
    WrDataEn  = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    TimerRst  = 1'b0;
    TimerLoad = '0;
    if (Reset) begin
      TimerRst = 1'b1;
    end else begin
      Busy = (state != IDLE);
      case (state)
        IDLE: ReqReady = 1'b1;
        ACT: begin
          Cmd       = CMD_ACT;
          CmdBank   = lat_bank;
          CmdAddr   = lat_row;
          TimerRst  = 1'b1;
          TimerLoad = LOAD_RCD;
        end
        CAS: begin
          Cmd       = lat_write ? CMD_WR : CMD_RD;
          CmdBank   = lat_bank;
          CmdAddr   = {7'b0, lat_col};
          TimerRst  = 1'b1;
          TimerLoad = lat_write ? LOAD_CWL : LOAD_CL;
        end
        BURST: begin
          RdDataEn = ~lat_write;
          WrDataEn = lat_write;
          if (last_beat) begin
            TimerRst  = 1'b1;
            TimerLoad = lat_write ? LOAD_WR : LOAD_RTP;
          end
        end
        PRE: begin
          Cmd       = CMD_PRE;
          CmdBank   = lat_bank;
          TimerRst  = 1'b1;
          TimerLoad = LOAD_RP;
        end
        WAIT_RP: Done = HitZero;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_timing_sequencer.sv
// Bench for cmd_timing_sequencer: one default-parameter instance and one
// minimum-parameter instance, each with a behavioural countdown timer.
module tb_cmd_timing_sequencer;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  cmd;
    logic [3:0]  bank;
    logic [16:0] addr;
    logic        rd;
    logic        wr;
    logic        dn;
  } ev_t;

  int P_RCD[2] = '{16, 2};
  int P_RP[2]  = '{16, 2};
  int P_CL[2]  = '{16, 2};
  int P_CWL[2] = '{12, 2};
  int P_WR[2]  = '{18, 1};
  int P_RTP[2] = '{9, 1};
  int P_BL[2]  = '{8, 4};

  logic clock = 1'b0;
  logic Reset = 1'b1;
  logic ReqWrite = 1'b0;
  logic [3:0]  ReqBank = '0;
  logic [16:0] ReqRow = '0;
  logic [9:0]  ReqCol = '0;
  logic spur = 1'b0;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  ev_t q0[$];
  ev_t q1[$];

  logic rv0 = 1'b0, rdy0, rde0, wre0, busy0, done0, trst0, hz0;
  logic [2:0] cmd0; logic [3:0] cb0; logic [16:0] ca0; logic [31:0] tload0;
  logic rv1 = 1'b0, rdy1, rde1, wre1, busy1, done1, trst1, hz1;
  logic [2:0] cmd1; logic [3:0] cb1; logic [16:0] ca1; logic [31:0] tload1;
  logic [31:0] tcnt0 = '0, tcnt1 = '0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  cmd_timing_sequencer dut (
    .clock(clock), .Reset(Reset), .ReqValid(rv0), .ReqReady(rdy0),
    .ReqWrite(ReqWrite), .ReqBank(ReqBank), .ReqRow(ReqRow), .ReqCol(ReqCol),
    .Cmd(cmd0), .CmdBank(cb0), .CmdAddr(ca0), .RdDataEn(rde0), .WrDataEn(wre0),
    .Busy(busy0), .Done(done0), .TimerRst(trst0), .TimerLoad(tload0), .HitZero(hz0)
  );

  cmd_timing_sequencer #(
    .T_RCD(2), .T_RP(2), .T_CL(2), .T_CWL(2), .T_WR(1), .T_RTP(1), .BL(4)
  ) dut_min (
    .clock(clock), .Reset(Reset), .ReqValid(rv1), .ReqReady(rdy1),
    .ReqWrite(ReqWrite), .ReqBank(ReqBank), .ReqRow(ReqRow), .ReqCol(ReqCol),
    .Cmd(cmd1), .CmdBank(cb1), .CmdAddr(ca1), .RdDataEn(rde1), .WrDataEn(wre1),
    .Busy(busy1), .Done(done1), .TimerRst(trst1), .TimerLoad(tload1), .HitZero(hz1)
  );

  // Countdown timers: load on TimerRst, otherwise decrement and wrap.
  always @(posedge clock) begin
    tcnt0 <= trst0 ? tload0 : tcnt0 - 32'd1;
    tcnt1 <= trst1 ? tload1 : tcnt1 - 32'd1;
  end
  assign hz0 = (tcnt0 == 32'd0) | spur;
  assign hz1 = (tcnt1 == 32'd0);

  function automatic ev_t mk(int cy, logic [2:0] cm, logic [3:0] b, logic [16:0] a,
                             logic rd, logic wr, logic dn);
    ev_t e;
    e.cyc = 32'(cy); e.cmd = cm; e.bank = b; e.addr = a; e.rd = rd; e.wr = wr; e.dn = dn;
    return e;
  endfunction

  function automatic void push(int k, ev_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic logic get_rdy(int k);
    return (k == 0) ? rdy0 : rdy1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard compare for one observed active cycle.
  task automatic mon_cmp(input int k, input ev_t o);
    ev_t e;
    vectors++;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      miscompares++;
      $display("FAIL unexpected_event dut%0d: got cyc=%0d cmd=%0d bank=%0h addr=%0h rd=%0b wr=%0b done=%0b",
               k, o.cyc, o.cmd, o.bank, o.addr, o.rd, o.wr, o.dn);
      return;
    end
    e = (k == 0) ? q0.pop_front() : q1.pop_front();
    if (e != o) begin
      miscompares++;
      $display("FAIL event dut%0d: got cyc=%0d cmd=%0d bank=%0h addr=%0h rd=%0b wr=%0b done=%0b, expected cyc=%0d cmd=%0d bank=%0h addr=%0h rd=%0b wr=%0b done=%0b",
               k, o.cyc, o.cmd, o.bank, o.addr, o.rd, o.wr, o.dn,
               e.cyc, e.cmd, e.bank, e.addr, e.rd, e.wr, e.dn);
    end
  endtask

  // Monitor: every cycle with a command, data enable or Done is an event.
  always @(posedge clock) begin
    #1;
    if (cmd0 != 3'b000 || rde0 || wre0 || done0)
      mon_cmp(0, mk(cyc, cmd0, cb0, ca0, rde0, wre0, done0));
    if (cmd1 != 3'b000 || rde1 || wre1 || done1)
      mon_cmp(1, mk(cyc, cmd1, cb1, ca1, rde1, wre1, done1));
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Offer a request; on acceptance push the full expected event sequence.
  task automatic issue(input int k, input bit w, input logic [3:0] b, input logic [16:0] r,
                       input logic [9:0] c, input bit abort, input bit hold, input int exp_acc,
                       output int acc, output int done_c);
    int waited, t, cas, d0, last, pre;
    ReqWrite = w; ReqBank = b; ReqRow = r; ReqCol = c;
    if (k == 0) rv0 = 1'b1; else rv1 = 1'b1;
    waited = 0; acc = -1; done_c = -1;
    while (!get_rdy(k) && waited < 300) begin
      @(negedge clock);
      waited++;
    end
    if (!get_rdy(k)) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout dut%0d: ReqReady=0 after %0d cycles, expected 1", k, waited);
      if (k == 0) rv0 = 1'b0; else rv1 = 1'b0;
      return;
    end
    acc = cyc;
    if (exp_acc >= 0) chk("accept_cycle", 32'(acc), 32'(exp_acc));
    t = acc + 1;
    cas = t + P_RCD[k];
    push(k, mk(t, 3'b001, b, r, 1'b0, 1'b0, 1'b0));
    push(k, mk(cas, w ? 3'b011 : 3'b010, b, {7'b0, c}, 1'b0, 1'b0, 1'b0));
    if (!abort) begin
      d0 = cas + (w ? P_CWL[k] : P_CL[k]);
      for (int i = 0; i < P_BL[k] / 2; i++)
        push(k, mk(d0 + i, 3'b000, 4'h0, 17'h0, ~w, w, 1'b0));
      last = d0 + P_BL[k] / 2 - 1;
      pre = last + (w ? P_WR[k] : P_RTP[k]) + 1;
      push(k, mk(pre, 3'b100, b, 17'h0, 1'b0, 1'b0, 1'b0));
      done_c = pre + P_RP[k] - 1;
      push(k, mk(done_c, 3'b000, 4'h0, 17'h0, 1'b0, 1'b0, 1'b1));
    end
    @(negedge clock);
    if (!hold) begin
      if (k == 0) rv0 = 1'b0; else rv1 = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc, dc, acc2, dc2, n;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    chk("rst_cmd", 32'(cmd0), 32'd0);
    chk("rst_timerrst", 32'(trst0), 32'd1);
    chk("rst_timerload", tload0, 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_min_timerrst", 32'(trst1), 32'd1);
    @(negedge clock);
    Reset = 1'b0;
    #1;
    chk("idle_ready", 32'(rdy0), 32'd1);
    chk("idle_busy", 32'(busy0), 32'd0);

    // Spurious HitZero in IDLE
    @(negedge clock);
    spur = 1'b1;
    repeat (3) @(negedge clock);
    spur = 1'b0;
    #1;
    chk("spur_idle_busy", 32'(busy0), 32'd0);
    chk("spur_idle_ready", 32'(rdy0), 32'd1);

    // Default read, with a spurious HitZero inside BURST
    @(negedge clock);
    issue(0, 1'b0, 4'h3, 17'h1ABCD, 10'h155, 1'b0, 1'b0, -1, acc, dc);
    wait_until(acc + 1 + 5);
    chk("mid_busy", 32'(busy0), 32'd1);
    chk("mid_ready", 32'(rdy0), 32'd0);
    wait_until(acc + 1 + 33);
    spur = 1'b1;
    @(negedge clock);
    spur = 1'b0;

    // Default write
    issue(0, 1'b1, 4'hA, 17'h00F0F, 10'h3FF, 1'b0, 1'b0, -1, acc, dc);

    // Two requests with ReqValid held throughout
    issue(0, 1'b0, 4'h5, 17'h10001, 10'h001, 1'b0, 1'b1, -1, acc, dc);
    issue(0, 1'b1, 4'hC, 17'h0FFFF, 10'h200, 1'b0, 1'b0, dc + 1, acc2, dc2);

    // Minimum-parameter instance: read then write
    issue(1, 1'b0, 4'h7, 17'h12345, 10'h2AA, 1'b0, 1'b0, -1, acc, dc);
    issue(1, 1'b1, 4'h1, 17'h00001, 10'h004, 1'b0, 1'b0, -1, acc, dc);

    // Reset during WAIT_LAT drops the request
    issue(0, 1'b0, 4'h9, 17'h0F00F, 10'h0AA, 1'b1, 1'b0, -1, acc, dc);
    wait_until(acc + 1 + 20);
    Reset = 1'b1;
    #1;
    chk("midrst_cmd", 32'(cmd0), 32'd0);
    chk("midrst_timerrst", 32'(trst0), 32'd1);
    chk("midrst_timerload", tload0, 32'd0);
    chk("midrst_rden", 32'(rde0), 32'd0);
    chk("midrst_busy", 32'(busy0), 32'd0);
    @(negedge clock);
    Reset = 1'b0;
    #1;
    chk("postrst_busy", 32'(busy0), 32'd0);
    chk("postrst_ready", 32'(rdy0), 32'd1);
    chk("postrst_cmd", 32'(cmd0), 32'd0);
    repeat (80) @(negedge clock);

    // Drain
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("queue0_drained", 32'(q0.size()), 32'd0);
    chk("queue1_drained", 32'(q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
